// File: rtl/cache_maint_pkg.sv
// Shared types and width helpers for the cache maintenance engine.
// Command codes mirror the cache control register block encodings.
package cache_maint_pkg;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_INIT  = 3'd1;
    localparam logic [2:0] CMD_CLEAR = 3'd2;
    localparam logic [2:0] CMD_WB    = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG_RD,
        ST_TAG_CHK,
        ST_WB_RD,
        ST_WB_WR,
        ST_TAG_WR,
        ST_NEXT,
        ST_DONE
    } maint_state_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned tag_width(input int unsigned sets, input int unsigned words);
        return 32 - $clog2(sets) - $clog2(words) - 2;
    endfunction

endpackage

// File: rtl/cache_maint_if.sv
// Memory-bus write port used for dirty-line writeback.
interface cache_maint_if;

    logic [31:0] address;
    logic [3:0]  byteEnable;
    logic        write;
    logic [31:0] writeData;
    logic        waitRequest;

    modport master (
        output address, byteEnable, write, writeData,
        input  waitRequest
    );

    modport slave (
        input  address, byteEnable, write, writeData,
        output waitRequest
    );

endinterface

// File: rtl/cache_maint_wb.sv
// Word sequencer for one dirty line: read data RAM word, push it on the bus, repeat.
// Raises done in the cycle the last word is accepted by the bus.
module cache_maint_wb
    import cache_maint_pkg::*;
#(
    parameter int unsigned SET_W  = 6,
    parameter int unsigned WORD_W = 3,
    parameter int unsigned TAG_W  = 21
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              start,
    input  logic [TAG_W-1:0]  tag,
    input  logic [SET_W-1:0]  set,
    output logic              done,
    output logic              data_read,
    output logic [WORD_W-1:0] word,
    input  logic [31:0]       data_rdata,
    cache_maint_if.master     m0
);

    maint_state_t      state, state_next;
    logic [WORD_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic              first_q;

    assign word = word_q;

    // RAM data is only valid in the first write cycle; the copy covers bus stalls.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state   <= ST_IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            first_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE:  if (start) word_q <= '0;
                ST_WB_RD: first_q <= 1'b1;
                ST_WB_WR: begin
                    if (first_q) wdata_q <= data_rdata;
                    first_q <= 1'b0;
                    if (!m0.waitRequest) word_q <= word_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        done          = 1'b0;
        data_read     = 1'b0;
        m0.write      = 1'b0;
        m0.byteEnable = '0;
        m0.address    = '0;
        m0.writeData  = '0;
        case (state)
            ST_IDLE: if (start) state_next = ST_WB_RD;
            ST_WB_RD: begin
                data_read  = 1'b1;
                state_next = ST_WB_WR;
            end
            ST_WB_WR: begin
                m0.write      = 1'b1;
                m0.byteEnable = 4'hF;
                m0.address    = {tag, set, word_q, 2'b00};
                m0.writeData  = first_q ? data_rdata : wdata_q;
                if (!m0.waitRequest) begin
                    if (word_q == '1) begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WB_RD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/cache_maint.sv
// Cache maintenance engine: sweeps every set/way for init / clear / wb commands.
// Optional CACHE_MAINT_STAT_EN adds a saturating count of written-back lines on wb_count.
module cache_maint
    import cache_maint_pkg::*;
#(
    parameter  int unsigned SET_NUM    = 64,
    parameter  int unsigned WAY_NUM    = 2,
    parameter  int unsigned LINE_WORDS = 8,
    localparam int unsigned SET_W      = $clog2(SET_NUM),
    localparam int unsigned WAY_W      = idx_width(WAY_NUM),
    localparam int unsigned WORD_W     = $clog2(LINE_WORDS),
    localparam int unsigned TAG_W      = tag_width(SET_NUM, LINE_WORDS)
) (
    input  logic                          clk,
    input  logic                          rest,
    input  logic [2:0]                    cmd,
    output logic                          cmd_ready,
    output logic                          maint_busy,
    output logic [SET_W-1:0]              tag_addr,
    output logic [WAY_W-1:0]              tag_way,
    output logic                          tag_read,
    input  logic [TAG_W+1:0]              tag_rdata,
    output logic                          tag_write,
    output logic [TAG_W+1:0]              tag_wdata,
    output logic [SET_W+WAY_W+WORD_W-1:0] data_addr,
    output logic                          data_read,
    input  logic [31:0]                   data_rdata,
    cache_maint_if.master                 m0,
    output logic [15:0]                   wb_count
);

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    maint_state_t      state, state_next;
    logic [2:0]        cmd_q;
    logic [SET_W-1:0]  set_q;
    logic [WAY_W-1:0]  way_q;
    logic [TAG_W-1:0]  tag_q;
    logic [WORD_W-1:0] wb_word;
    logic              wb_start, wb_done;
    logic              accept, last_line;
    tag_entry_t        rd_entry, wr_entry;

    assign rd_entry   = tag_rdata;
    assign tag_wdata  = wr_entry;
    assign accept     = (state == ST_IDLE) &&
                        (cmd == CMD_INIT || cmd == CMD_CLEAR || cmd == CMD_WB);
    assign last_line  = (set_q == '1) && (way_q == WAY_W'(WAY_NUM - 1));
    assign tag_addr   = set_q;
    assign tag_way    = way_q;
    assign data_addr  = {set_q, way_q, wb_word};
    assign maint_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state <= ST_IDLE;
            cmd_q <= CMD_NOP;
            set_q <= '0;
            way_q <= '0;
            tag_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cmd_q <= cmd;
                set_q <= '0;
                way_q <= '0;
            end
            if (state == ST_TAG_CHK) tag_q <= rd_entry.tag;
            if (state == ST_NEXT) begin
                if (way_q == WAY_W'(WAY_NUM - 1)) begin
                    way_q <= '0;
                    set_q <= set_q + 1'b1;
                end else begin
                    way_q <= way_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        tag_read   = 1'b0;
        tag_write  = 1'b0;
        wr_entry   = '0;
        cmd_ready  = 1'b0;
        wb_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd == CMD_INIT)
                    state_next = ST_TAG_WR;
                else if (cmd == CMD_CLEAR || cmd == CMD_WB)
                    state_next = ST_TAG_RD;
            end
            ST_TAG_RD: begin
                tag_read   = 1'b1;
                state_next = ST_TAG_CHK;
            end
            ST_TAG_CHK: begin
                if (rd_entry.valid && rd_entry.dirty) begin
                    wb_start   = 1'b1;
                    state_next = ST_WB_RD;
                end else if (cmd_q == CMD_CLEAR && rd_entry.valid) begin
                    state_next = ST_TAG_WR;
                end else begin
                    state_next = ST_NEXT;
                end
            end
            // The word sequencer owns the read/write phases of the line.
            ST_WB_RD: if (wb_done) state_next = ST_TAG_WR;
            ST_TAG_WR: begin
                tag_write = 1'b1;
                if (cmd_q == CMD_WB) wr_entry = '{valid: 1'b1, dirty: 1'b0, tag: tag_q};
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (last_line)
                    state_next = ST_DONE;
                else if (cmd_q == CMD_INIT)
                    state_next = ST_TAG_WR;
                else
                    state_next = ST_TAG_RD;
            end
            ST_DONE: begin
                cmd_ready  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    cache_maint_wb #(
        .SET_W  (SET_W),
        .WORD_W (WORD_W),
        .TAG_W  (TAG_W)
    ) u_wb (
        .clk        (clk),
        .rest       (rest),
        .start      (wb_start),
        .tag        (tag_q),
        .set        (set_q),
        .done       (wb_done),
        .data_read  (data_read),
        .word       (wb_word),
        .data_rdata (data_rdata),
        .m0         (m0)
    );

`ifdef CACHE_MAINT_STAT_EN
    logic [15:0] wb_cnt_q;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest)
            wb_cnt_q <= '0;
        else if (accept)
            wb_cnt_q <= '0;
        else if (wb_done && wb_cnt_q != 16'hFFFF)
            wb_cnt_q <= wb_cnt_q + 16'd1;
    end

    assign wb_count = wb_cnt_q;
`else
    assign wb_count = '0;
`endif

endmodule

// File: tb/tb_cache_maint.sv
// Randomized bench for cache_maint against a line-level sweep model (SET_NUM=4, WAY_NUM=2, LINE_WORDS=4).
module tb_cache_maint;
    import cache_maint_pkg::*;

    localparam int unsigned SET_NUM    = 4;
    localparam int unsigned WAY_NUM    = 2;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINES      = SET_NUM * WAY_NUM;

    logic        clk = 1'b0;
    logic        rest = 1'b0;
    logic [2:0]  cmd = CMD_INIT;
    logic        cmd_ready, maint_busy;
    logic [1:0]  tag_addr;
    logic [0:0]  tag_way;
    logic        tag_read, tag_write;
    logic [27:0] tag_rdata = '0;
    logic [27:0] tag_wdata;
    logic [4:0]  data_addr;
    logic        data_read;
    logic [31:0] data_rdata = '0;
    logic [15:0] wb_count;

    cache_maint_if m0();

    cache_maint #(
        .SET_NUM    (SET_NUM),
        .WAY_NUM    (WAY_NUM),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk        (clk),
        .rest       (rest),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .maint_busy (maint_busy),
        .tag_addr   (tag_addr),
        .tag_way    (tag_way),
        .tag_read   (tag_read),
        .tag_rdata  (tag_rdata),
        .tag_write  (tag_write),
        .tag_wdata  (tag_wdata),
        .data_addr  (data_addr),
        .data_read  (data_read),
        .data_rdata (data_rdata),
        .m0         (m0),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM models and bus monitor
    logic [27:0] tag_mem  [LINES];
    logic [31:0] data_mem [LINES*LINE_WORDS];
    logic [63:0] wr_q[$];
    int unsigned tag_wr_cnt = 0, ready_cnt = 0, strobe_cnt = 0, busy_cnt = 0;

    always @(posedge clk) begin
        if (tag_read)  tag_rdata  <= tag_mem[{tag_addr, tag_way}];
        if (data_read) data_rdata <= data_mem[data_addr];
        if (tag_write) tag_mem[{tag_addr, tag_way}] = tag_wdata;
        if (m0.write && !m0.waitRequest) wr_q.push_back({m0.address, m0.writeData});
        tag_wr_cnt <= tag_wr_cnt + (tag_write ? 1 : 0);
        ready_cnt  <= ready_cnt + (cmd_ready ? 1 : 0);
        busy_cnt   <= busy_cnt + (maint_busy ? 1 : 0);
        strobe_cnt <= strobe_cnt + ((tag_read || tag_write || data_read || m0.write) ? 1 : 0);
    end

    // Bus slave stall generator; a stalled write must be re-presented unchanged.
    int unsigned stall_mode = 0;
    int unsigned stall_left = 0;
    logic        prev_wr = 1'b0, prev_wait = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always @(negedge clk) begin
        if (rest && prev_wr && prev_wait) begin
            check("hold_write", m0.write, 1);
            check("hold_addr", m0.address, prev_addr);
            check("hold_data", m0.writeData, prev_data);
        end
        case (stall_mode)
            1: m0.waitRequest = m0.write && ($urandom_range(0, 2) == 0);
            2: begin
                if (m0.write && m0.address[3:2] == 2'd2 && stall_left > 0) begin
                    m0.waitRequest = 1'b1;
                    stall_left--;
                    check("stall_addr", m0.address, 32'h0048D168);
                end else begin
                    m0.waitRequest = 1'b0;
                end
            end
            default: m0.waitRequest = 1'b0;
        endcase
        prev_wr   = rest && m0.write;
        prev_wait = m0.waitRequest;
        prev_addr = m0.address;
        prev_data = m0.writeData;
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, cmd_ready, 0);
        check({tag, "_busy"}, maint_busy, 0);
        check({tag, "_strobes"}, {tag_read, tag_write, data_read, m0.write}, 0);
        check({tag, "_addrs"}, {tag_addr, tag_way, data_addr}, 0);
        check({tag, "_tag_wdata"}, tag_wdata, 0);
        check({tag, "_m0_addr"}, m0.address, 0);
        check({tag, "_m0_data"}, m0.writeData, 0);
        check({tag, "_m0_be"}, m0.byteEnable, 0);
        check({tag, "_wb_count"}, wb_count, 0);
    endtask

    // Issues c (releasing reset if held) and returns cycles from the sampling edge to cmd_ready.
    task automatic run_cmd(input logic [2:0] c, output int unsigned lat);
        int unsigned cyc = 0;
        bit          seen = 0;
        @(negedge clk);
        wr_q.delete();
        cmd  = c;
        rest = 1'b1;
        while (!seen && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cmd_ready) seen = 1;
        end
        cmd = CMD_NOP;
        check("ready_seen", seen, 1);
        lat = cyc;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: walk the lines in set-major/way-minor order and apply the command rules.
    task automatic run_and_check(input logic [2:0] c, input string name);
        logic [27:0] snap    [LINES];
        logic [27:0] exp_tag [LINES];
        logic [63:0] exp_wr[$];
        int unsigned exp_tw = 0, exp_lines = 0, lat, tw0, rdy0, n;
        snap    = tag_mem;
        exp_tag = tag_mem;
        for (int unsigned s = 0; s < SET_NUM; s++) begin
            for (int unsigned w = 0; w < WAY_NUM; w++) begin
                int unsigned idx = s * WAY_NUM + w;
                logic        v = snap[idx][27];
                logic        d = snap[idx][26];
                logic [31:0] t = 32'(snap[idx][25:0]);
                if (c == CMD_INIT) begin
                    exp_tag[idx] = '0;
                    exp_tw++;
                end else if (v && d) begin
                    for (int unsigned k = 0; k < LINE_WORDS; k++)
                        exp_wr.push_back({t * 64 + s * 16 + k * 4, data_mem[idx * LINE_WORDS + k]});
                    exp_tag[idx] = (c == CMD_WB) ? 28'((1 << 27) + t) : 28'd0;
                    exp_tw++;
                    exp_lines++;
                end else if (c == CMD_CLEAR && v) begin
                    exp_tag[idx] = '0;
                    exp_tw++;
                end
            end
        end
        tw0  = tag_wr_cnt;
        rdy0 = ready_cnt;
        run_cmd(c, lat);
        check({name, "_nwrites"}, wr_q.size(), exp_wr.size());
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int unsigned i = 0; i < n; i++) check({name, "_write"}, wr_q[i], exp_wr[i]);
        for (int unsigned i = 0; i < LINES; i++) check({name, "_tag"}, tag_mem[i], exp_tag[i]);
        check({name, "_ntagwr"}, tag_wr_cnt - tw0, exp_tw);
        check({name, "_nready"}, ready_cnt - rdy0, 1);
        check({name, "_busy_after"}, maint_busy, 0);
`ifdef CACHE_MAINT_STAT_EN
        check({name, "_wb_count"}, wb_count, exp_lines);
`else
        check({name, "_wb_count"}, wb_count, 0);
`endif
        if (c == CMD_INIT) check({name, "_latency"}, lat, 2 * LINES + 1);
    endtask

    task automatic fill_data();
        for (int unsigned i = 0; i < LINES * LINE_WORDS; i++) data_mem[i] = $urandom;
    endtask

    // Every line valid and clean except set2/way1, which holds dirty tag 0x12345.
    task automatic setup_one_dirty();
        for (int unsigned i = 0; i < LINES; i++) tag_mem[i] = {2'b10, 26'($urandom)};
        tag_mem[2 * WAY_NUM + 1] = {2'b11, 26'h12345};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned s0, r0, b0, cyc;
        logic [2:0]  codes[5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int unsigned i = 0; i < LINES; i++) tag_mem[i] = 28'($urandom);
        fill_data();

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");

        // init accepted on the first edge after reset release
        run_and_check(CMD_INIT, "init_first");

        setup_one_dirty();
        run_and_check(CMD_WB, "wb_one");
        check("wb_one_addr0", wr_q.size() > 0 ? {32'h0, wr_q[0][63:32]} : 64'h0, 64'h48D160);

        setup_one_dirty();
        run_and_check(CMD_CLEAR, "clear_one");

        setup_one_dirty();
        stall_mode = 2;
        stall_left = 5;
        run_and_check(CMD_WB, "wb_stall");
        check("stall_used", stall_left, 0);
        stall_mode = 0;

        // reset in the middle of a writeback
        setup_one_dirty();
        @(negedge clk);
        cmd = CMD_WB;
        cyc = 0;
        while (!m0.write && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wb_started", m0.write, 1);
        #2;
        rest = 1'b0;
        #1;
        check_quiet("async_rst");
        cmd = CMD_NOP;
        repeat (2) @(negedge clk);
        run_and_check(CMD_INIT, "init_after_rst");

        // nop and unused codes leave the engine idle
        s0 = strobe_cnt;
        r0 = ready_cnt;
        b0 = busy_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cmd = codes[i % 5];
        end
        @(negedge clk);
        cmd = CMD_NOP;
        repeat (2) @(posedge clk);
        #1;
        check("nop_strobes", strobe_cnt - s0, 0);
        check("nop_ready", ready_cnt - r0, 0);
        check("nop_busy", busy_cnt - b0, 0);

        // two dirty lines
        for (int unsigned i = 0; i < LINES; i++) tag_mem[i] = {2'b10, 26'($urandom)};
        tag_mem[1] = {2'b11, 26'h3ABCD};
        tag_mem[6] = {2'b11, 26'h0F00F};
        run_and_check(CMD_WB, "wb_two");
`ifdef CACHE_MAINT_STAT_EN
        check("wb_two_count", wb_count, 2);
`else
        check("wb_two_count", wb_count, 0);
`endif

        // randomized sweeps with random bus stalls
        stall_mode = 1;
        for (int unsigned it = 0; it < 10; it++) begin
            logic [2:0] c;
            for (int unsigned i = 0; i < LINES; i++) tag_mem[i] = 28'($urandom);
            fill_data();
            case ($urandom_range(0, 2))
                0:       c = CMD_INIT;
                1:       c = CMD_CLEAR;
                default: c = CMD_WB;
            endcase
            run_and_check(c, "rand");
        end
        stall_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
